// File: rtl/iterative_shift_unit_if.sv
// Handshake and data bundle for the iterative shift unit.
// The master side issues operands and consumes results; the slave side is
// the shift unit itself.
interface iterative_shift_unit_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
);
    // Request channel
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [SHAMT_W-1:0] Shift_value;
    logic [1:0]         Mode;

    // Response channel
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   Result;
    logic               Range_err;

    // Status
    logic               Busy;

    modport master (
        output in_valid,
        output A,
        output Shift_value,
        output Mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Result,
        input  Range_err,
        input  Busy
    );

    modport slave (
        input  in_valid,
        input  A,
        input  Shift_value,
        input  Mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Result,
        output Range_err,
        output Busy
    );
endinterface

// File: rtl/iterative_shift_unit.sv
// Iterative multi-mode shifter (LSR / LSL / ASR / ROR).
// An accepted operand is shifted up to STEP positions per cycle in the SHIFT
// state, then presented in DONE until the consumer takes it. Out-of-range
// shift amounts skip SHIFT entirely and report Range_err with A unchanged.
module iterative_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH) + 1,
    parameter int STEP    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iterative_shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_LSL = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Largest legal shift amount and the per-cycle stepping limit.
    localparam logic [SHAMT_W-1:0] MAX_SHAMT = SHAMT_W'(WIDTH - 1);
    localparam logic [SHAMT_W-1:0] STEP_AMT  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] ZERO_AMT  = {SHAMT_W{1'b0}};

    // Single-position shift for the selected mode.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] value,
        input logic [1:0]       mode
    );
        logic [WIDTH-1:0] res;
        case (mode)
            MODE_LSR: res = {1'b0, value[WIDTH-1:1]};
            MODE_LSL: res = {value[WIDTH-2:0], 1'b0};
            MODE_ASR: res = {value[WIDTH-1], value[WIDTH-1:1]};
            MODE_ROR: res = {value[0], value[WIDTH-1:1]};
            default:  res = value;
        endcase
        return res;
    endfunction

    // Shift by 'amount' positions (amount <= STEP) as a chain of STEP
    // conditional single-position stages; stages beyond 'amount' pass through.
    function automatic logic [WIDTH-1:0] shift_by(
        input logic [WIDTH-1:0]   value,
        input logic [1:0]         mode,
        input logic [SHAMT_W-1:0] amount
    );
        logic [WIDTH-1:0] res;
        res = value;
        for (int i = 0; i < STEP; i++) begin
            if (SHAMT_W'(i) < amount) begin
                res = shift_one(res, mode);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // State and datapath registers
    state_e             r_state;
    logic [WIDTH-1:0]   r_result;
    logic               r_range_err;
    logic [SHAMT_W-1:0] r_remaining;
    logic [1:0]         r_mode;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    // Next-state values
    state_e             w_next_state;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_range_err_nxt;
    logic [SHAMT_W-1:0] w_remaining_nxt;
    logic [1:0]         w_mode_nxt;

    // Per-cycle step helpers
    logic [SHAMT_W-1:0] w_step_amt;
    logic [SHAMT_W-1:0] w_rem_after;
    logic [WIDTH-1:0]   w_shifted;

    // Step size for this SHIFT cycle: min(STEP, remaining) and the shifted value.
    always_comb begin
        w_step_amt  = (r_remaining < STEP_AMT) ? r_remaining : STEP_AMT;
        w_rem_after = r_remaining - w_step_amt;
        w_shifted   = shift_by(r_result, r_mode, w_step_amt);
    end

    // Next-state and datapath update logic; registers hold unless a state acts.
    always_comb begin
        w_next_state    = r_state;
        w_result_nxt    = r_result;
        w_range_err_nxt = r_range_err;
        w_remaining_nxt = r_remaining;
        w_mode_nxt      = r_mode;

        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_result_nxt    = bus.A;
                    w_mode_nxt      = bus.Mode;
                    w_remaining_nxt = bus.Shift_value;
                    if (bus.Shift_value > MAX_SHAMT) begin
                        w_range_err_nxt = 1'b1;
                        w_next_state    = ST_DONE;
                    end else if (bus.Shift_value == ZERO_AMT) begin
                        w_range_err_nxt = 1'b0;
                        w_next_state    = ST_DONE;
                    end else begin
                        w_range_err_nxt = 1'b0;
                        w_next_state    = ST_SHIFT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                w_result_nxt    = w_shifted;
                w_remaining_nxt = w_rem_after;
                if (w_rem_after == ZERO_AMT) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end

            ST_DONE: begin
                // Result is held until the consumer takes it; the request side
                // stays closed for this cycle even if the result is taken.
                if (bus.out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath registers: result, range flag, remaining count and mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= {WIDTH{1'b0}};
            r_range_err <= 1'b0;
            r_remaining <= {SHAMT_W{1'b0}};
            r_mode      <= 2'b00;
        end else begin
            r_result    <= w_result_nxt;
            r_range_err <= w_range_err_nxt;
            r_remaining <= w_remaining_nxt;
            r_mode      <= w_mode_nxt;
        end
    end

    // Registered status outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == ST_DONE);
            r_in_ready  <= (w_next_state == ST_IDLE);
            r_busy      <= (w_next_state != ST_IDLE);
        end
    end

    assign bus.Result    = r_result;
    assign bus.Range_err = r_range_err;
    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.Busy      = r_busy;

endmodule
